tm1638_responder: RTL and testbench
===================================

Name: tm1638_responder

Overview:
- Synthesizable device-side emulation of a TM1638 on the 3-wire STB/CLK/DIO bus; the responder to the tm1638_drv-based host controller.
- Decodes data, display-control and address commands, and holds a 16-byte display RAM plus brightness and on/off state.
- On a key-read command, shifts a 32-bit key-scan word back to the host.
- Used as a loopback target in system benches and as an on-FPGA panel emulator.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for STB, CLK and DIO input pins (minimum 2).
- KEY_BYTES, 4, bytes returned per key read (fixed at 4; TM1638 format).

Ports:
- CLK_IN  input  1  system clock; must be at least 8x the bus SCLK rate.
- RST_IN  input  1  asynchronous, active-low reset.
- TM1638_STB  input  1  bus strobe; frame active while low.
- TM1638_CLK  input  1  bus serial clock.
- DIO_IN  input  1  DIO pad input.
- DIO_OUT  output  1  DIO pad output value.
- DIO_OE  output  1  DIO pad output enable (1 = drive).
- KEY_SCAN_I  input  32  key data; bit n is the n-th bit sent (byte0 LSB first).
- DISP_RAM_O  output  128  display RAM; byte at address a is bits [8a+7:8a].
- BRIGHTNESS_O  output  3  pulse-width setting from display control.
- DISPLAY_ON_O  output  1  display enable from display control.
- FRAME_DONE_O  output  1  1-cycle pulse when a frame with at least 1 complete byte ends.
- CMD_ERR_O  output  1  1-cycle pulse when an unsupported command byte is received.

Behaviour:
- Reset values:
  - DISP_RAM_O = 0, BRIGHTNESS_O = 0, DISPLAY_ON_O = 0.
  - DIO_OUT = 0, DIO_OE = 0, FRAME_DONE_O = 0, CMD_ERR_O = 0.
  - Address pointer = 0, addressing mode = auto-increment, state = IDLE.
- Input synchronization and edge timing:
  - STB, CLK and DIO pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized CLK and STB.
  - Internal events occur SYNC_STAGES+1 CLK_IN cycles after the pin edge.
- Serial format:
  - LSB first.
  - The device samples DIO on each CLK rising edge.
  - The device updates DIO_OUT on each CLK falling edge.
- STB low starts a frame; the first 8 bits form the command byte.
- Command decode on bits [7:6] of the command byte:
  - 01 = data command.
    - Bits [1:0]: 00 = write mode, 10 = read keys, anything else = error.
    - Bit 2: 1 = fixed address, 0 = auto-increment.
    - Bit 2 persists across frames.
  - 10 = display control: DISPLAY_ON_O = bit3, BRIGHTNESS_O = bits [2:0]; both update in the cycle the byte completes.
  - 11 = address set: pointer = bits [3:0].
  - 00 = error: pulse CMD_ERR_O, no state change, remaining frame bits ignored.
  - A data command with invalid bits [1:0] likewise pulses CMD_ERR_O, leaves mode unchanged and ignores the rest of the frame.
- States:
  - IDLE: STB high; goes to CMD on STB fall.
  - CMD: shifting the command byte; goes to WDATA (address set), RKEYS (read keys), or IGNORE (all other commands and errors).
  - WDATA: each completed byte is written to RAM[pointer].
    - Auto mode: pointer increments and wraps 15 -> 0.
    - Fixed mode: pointer holds, so later bytes overwrite the same address.
  - RKEYS: KEY_SCAN_I is snapshotted when the command byte completes.
    - On the next CLK fall, DIO_OE = 1 and DIO_OUT = bit0.
    - Each following CLK fall presents the next bit.
    - On the CLK fall after bit31, DIO_OE = 0 and the state goes to IGNORE.
  - IGNORE: discards bits until STB rises.
- STB rise from any state:
  - Return to IDLE, DIO_OE = 0, partial byte discarded (no RAM write).
  - FRAME_DONE_O pulses if at least 1 complete byte was received.
- DIO_OE is never 1 outside RKEYS.
- CLK edges while STB is high are ignored.
- Reset mid-frame returns all state to reset values immediately (asynchronous).

Test Plan:
- Display control: frame 0x8F -> DISPLAY_ON_O = 1, BRIGHTNESS_O = 7, FRAME_DONE_O pulses once, DIO_OE stays 0.
- Auto-increment write with wrap:
  - Frame 0x40, then frame 0xCE + 0xAA, 0xBB, 0xCC.
  - Required: RAM[14] = 0xAA, RAM[15] = 0xBB, RAM[0] = 0xCC, all other bytes 0.
- Fixed-address write: frame 0x44, then frame 0xC3 + 0x12, 0x34 -> RAM[3] = 0x34, RAM[4] = 0.
- Key read:
  - KEY_SCAN_I = 0x80402010, frame 0x42 followed by 32 host clocks.
  - Host samples bytes 0x10, 0x20, 0x40, 0x80.
  - DIO_OE is 0 during the command byte and 0 again after bit31.
- Abort and error:
  - STB rises after 5 bits of a data byte in WDATA -> RAM unchanged.
  - Frame 0x41 -> CMD_ERR_O pulses once, mode unchanged.
  - Frame 0x05 -> CMD_ERR_O pulses.
- Reset mid-read: RST_IN low during bit 10 of a key read -> DIO_OE = 0 immediately, all outputs at reset values, and the next 0x8F frame works normally.

Source files
------------

// File: rtl/tm1638_responder.sv
// rtl/tm1638_responder.sv - device-side TM1638 bus emulation
// Decodes host frames into display RAM/control state and shifts key-scan data back on reads.
module tm1638_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int KEY_BYTES   = 4
) (
   input  logic         CLK_IN,
   input  logic         RST_IN,
   input  logic         TM1638_STB,
   input  logic         TM1638_CLK,
   input  logic         DIO_IN,
   output logic         DIO_OUT,
   output logic         DIO_OE,
   input  logic [31:0]  KEY_SCAN_I,
   output logic [127:0] DISP_RAM_O,
   output logic [2:0]   BRIGHTNESS_O,
   output logic         DISPLAY_ON_O,
   output logic         FRAME_DONE_O,
   output logic         CMD_ERR_O
);

   localparam logic [5:0] KEY_BITS = 6'(KEY_BYTES * 8);

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WDATA,
      RKEYS,
      IGNORE
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] stb_sr, clk_sr, dio_sr;
   logic                   stb_s, clk_s, dio_s;
   logic                   stb_q, clk_q;

   logic       stb_fall, stb_rise, clk_rise, clk_fall;
   logic [7:0] shift_q, sh_next;
   logic [2:0] bit_cnt_q;
   logic       byte_seen_q;
   logic       byte_done;
   logic       cmd_done;
   logic       data_ok;
   logic       cmd_err;

   logic [3:0]   addr_q;
   logic         fixed_q;
   logic [31:0]  key_snap_q;
   logic [5:0]   key_idx_q;
   logic [127:0] disp_ram_q;

   // Pins idle high for STB/CLK so a reset release never fakes a frame start.
   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         stb_sr <= '1;
         clk_sr <= '1;
         dio_sr <= '0;
         stb_q  <= 1'b1;
         clk_q  <= 1'b1;
      end else begin
         stb_sr <= {stb_sr[SYNC_STAGES-2:0], TM1638_STB};
         clk_sr <= {clk_sr[SYNC_STAGES-2:0], TM1638_CLK};
         dio_sr <= {dio_sr[SYNC_STAGES-2:0], DIO_IN};
         stb_q  <= stb_s;
         clk_q  <= clk_s;
      end
   end

   assign stb_s = stb_sr[SYNC_STAGES-1];
   assign clk_s = clk_sr[SYNC_STAGES-1];
   assign dio_s = dio_sr[SYNC_STAGES-1];

   assign stb_fall = stb_q & ~stb_s;
   assign stb_rise = ~stb_q & stb_s;
   assign clk_rise = ~clk_q & clk_s & ~stb_s;
   assign clk_fall = clk_q & ~clk_s & ~stb_s;
   assign sh_next  = {dio_s, shift_q[7:1]};

   always_comb begin
      state_d   = state_q;
      byte_done = 1'b0;
      cmd_done  = 1'b0;
      cmd_err   = 1'b0;
      data_ok   = (sh_next[1:0] == 2'b00) || (sh_next[1:0] == 2'b10);

      if ((state_q == CMD || state_q == WDATA) && clk_rise && bit_cnt_q == 3'd7)
         byte_done = 1'b1;

      case (state_q)
         IDLE: begin
            if (stb_fall)
               state_d = CMD;
         end
         CMD: begin
            if (byte_done) begin
               cmd_done = 1'b1;
               state_d  = IGNORE;
               case (sh_next[7:6])
                  2'b01: begin
                     if (!data_ok)
                        cmd_err = 1'b1;
                     else if (sh_next[1])
                        state_d = RKEYS;
                  end
                  2'b11:   state_d = WDATA;
                  2'b00:   cmd_err = 1'b1;
                  default: state_d = IGNORE;
               endcase
            end
         end
         RKEYS: begin
            if (clk_fall && key_idx_q == KEY_BITS)
               state_d = IGNORE;
         end
         default: state_d = state_q;
      endcase

      if (state_q != IDLE && stb_rise)
         state_d = IDLE;
   end

   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         shift_q      <= '0;
         bit_cnt_q    <= '0;
         byte_seen_q  <= 1'b0;
         addr_q       <= '0;
         fixed_q      <= 1'b0;
         key_snap_q   <= '0;
         key_idx_q    <= '0;
         disp_ram_q   <= '0;
         BRIGHTNESS_O <= '0;
         DISPLAY_ON_O <= 1'b0;
         FRAME_DONE_O <= 1'b0;
         CMD_ERR_O    <= 1'b0;
         DIO_OUT      <= 1'b0;
         DIO_OE       <= 1'b0;
      end else begin
         FRAME_DONE_O <= stb_rise && state_q != IDLE && byte_seen_q;
         CMD_ERR_O    <= cmd_err;

         if (stb_fall) begin
            bit_cnt_q   <= '0;
            byte_seen_q <= 1'b0;
         end else if ((state_q == CMD || state_q == WDATA) && clk_rise) begin
            shift_q   <= sh_next;
            bit_cnt_q <= bit_cnt_q + 3'd1;
         end

         if (byte_done)
            byte_seen_q <= 1'b1;

         if (cmd_done && !cmd_err) begin
            case (sh_next[7:6])
               2'b01: begin
                  fixed_q <= sh_next[2];
                  if (sh_next[1]) begin
                     key_snap_q <= KEY_SCAN_I;
                     key_idx_q  <= '0;
                  end
               end
               2'b10: begin
                  DISPLAY_ON_O <= sh_next[3];
                  BRIGHTNESS_O <= sh_next[2:0];
               end
               2'b11:   addr_q <= sh_next[3:0];
               default: ;
            endcase
         end

         if (state_q == WDATA && byte_done) begin
            disp_ram_q[{addr_q, 3'b000} +: 8] <= sh_next;
            if (!fixed_q)
               addr_q <= addr_q + 4'd1;
         end

         // The pad is only ever driven while the state machine stays in RKEYS.
         if (state_d != RKEYS) begin
            DIO_OE  <= 1'b0;
            DIO_OUT <= 1'b0;
         end else if (state_q == RKEYS && clk_fall) begin
            DIO_OE    <= 1'b1;
            DIO_OUT   <= key_snap_q[key_idx_q[4:0]];
            key_idx_q <= key_idx_q + 6'd1;
         end
      end
   end

   assign DISP_RAM_O = disp_ram_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// tb/tb_tm1638_responder.sv - directed self-checking bench for tm1638_responder
module tb_tm1638_responder;

   localparam int H = 10;

   logic         clk;
   logic         rst_n;
   logic         stb;
   logic         tm_clk;
   logic         dio;
   logic         dio_out;
   logic         dio_oe;
   logic [31:0]  key_scan;
   logic [127:0] disp_ram;
   logic [2:0]   brightness;
   logic         display_on;
   logic         frame_done;
   logic         cmd_err;

   int n_tests = 0;
   int n_fail  = 0;
   int fd_cnt  = 0;
   int err_cnt = 0;
   int oe_bad  = 0;
   int oe_low  = 0;
   int fd_base;
   int err_base;
   logic in_read = 1'b0;
   logic [127:0] exp_ram;
   logic [31:0]  rx;

   tm1638_responder #(.SYNC_STAGES(2), .KEY_BYTES(4)) dut (
      .CLK_IN      (clk),
      .RST_IN      (rst_n),
      .TM1638_STB  (stb),
      .TM1638_CLK  (tm_clk),
      .DIO_IN      (dio),
      .DIO_OUT     (dio_out),
      .DIO_OE      (dio_oe),
      .KEY_SCAN_I  (key_scan),
      .DISP_RAM_O  (disp_ram),
      .BRIGHTNESS_O(brightness),
      .DISPLAY_ON_O(display_on),
      .FRAME_DONE_O(frame_done),
      .CMD_ERR_O   (cmd_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done) fd_cnt++;
      if (cmd_err) err_cnt++;
      if (dio_oe && !in_read) oe_bad++;
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      for (int i = 0; i < n; i++) begin
         tm_clk = 1'b0;
         dio    = b[i];
         wait_cyc(H);
         tm_clk = 1'b1;
         wait_cyc(H);
      end
   endtask

   task automatic start_frame();
      stb = 1'b0;
      wait_cyc(H);
   endtask

   task automatic end_frame();
      stb = 1'b1;
      wait_cyc(2 * H);
   endtask

   task automatic frame1(input logic [7:0] b);
      start_frame();
      send_bits(b, 8);
      end_frame();
   endtask

   initial begin
      rst_n    = 1'b0;
      stb      = 1'b1;
      tm_clk   = 1'b1;
      dio      = 1'b0;
      key_scan = 32'h0;
      exp_ram  = '0;
      wait_cyc(4);
      check("reset_ram", disp_ram, 128'h0);
      check("reset_bright", 128'(brightness), 128'h0);
      check("reset_on", 128'(display_on), 128'h0);
      check("reset_oe", 128'(dio_oe), 128'h0);
      check("reset_dout", 128'(dio_out), 128'h0);
      check("reset_pulses", 128'({frame_done, cmd_err}), 128'h0);
      rst_n = 1'b1;
      wait_cyc(4);

      // display control
      fd_base = fd_cnt; err_base = err_cnt;
      frame1(8'h8F);
      check("disp_on", 128'(display_on), 128'h1);
      check("disp_bright", 128'(brightness), 128'h7);
      check("disp_fd_once", 128'(fd_cnt - fd_base), 128'h1);
      check("disp_no_err", 128'(err_cnt - err_base), 128'h0);
      check("disp_oe_never", 128'(oe_bad), 128'h0);

      // auto-increment write wrapping 15 -> 0
      fd_base = fd_cnt;
      frame1(8'h40);
      start_frame();
      send_bits(8'hCE, 8);
      send_bits(8'hAA, 8);
      send_bits(8'hBB, 8);
      send_bits(8'hCC, 8);
      end_frame();
      exp_ram[14*8 +: 8] = 8'hAA;
      exp_ram[15*8 +: 8] = 8'hBB;
      exp_ram[0*8 +: 8]  = 8'hCC;
      check("auto_wrap_ram", disp_ram, exp_ram);
      check("auto_fd_count", 128'(fd_cnt - fd_base), 128'h2);

      // fixed-address write
      frame1(8'h44);
      start_frame();
      send_bits(8'hC3, 8);
      send_bits(8'h12, 8);
      send_bits(8'h34, 8);
      end_frame();
      exp_ram[3*8 +: 8] = 8'h34;
      check("fixed_ram3", 128'(disp_ram[3*8 +: 8]), 128'h34);
      check("fixed_ram4", 128'(disp_ram[4*8 +: 8]), 128'h0);
      check("fixed_ram_all", disp_ram, exp_ram);

      // key read; scan input changes after the command to prove the snapshot
      key_scan = 32'h80402010;
      start_frame();
      send_bits(8'h42, 8);
      check("keys_oe_cmd", 128'(dio_oe), 128'h0);
      key_scan = 32'h0;
      in_read = 1'b1;
      oe_low  = 0;
      rx      = '0;
      for (int i = 0; i < 32; i++) begin
         tm_clk = 1'b0;
         wait_cyc(H);
         rx[i] = dio_out;
         if (!dio_oe) oe_low++;
         tm_clk = 1'b1;
         wait_cyc(H);
      end
      check("keys_byte0", 128'(rx[7:0]), 128'h10);
      check("keys_byte1", 128'(rx[15:8]), 128'h20);
      check("keys_byte2", 128'(rx[23:16]), 128'h40);
      check("keys_byte3", 128'(rx[31:24]), 128'h80);
      check("keys_oe_driving", 128'(oe_low), 128'h0);
      tm_clk = 1'b0;
      wait_cyc(H);
      check("keys_oe_after31", 128'(dio_oe), 128'h0);
      in_read = 1'b0;
      tm_clk = 1'b1;
      wait_cyc(H);
      end_frame();
      check("keys_oe_outside", 128'(oe_bad), 128'h0);

      // abort after 5 bits of a data byte
      fd_base = fd_cnt;
      start_frame();
      send_bits(8'hC5, 8);
      send_bits(8'hFF, 5);
      end_frame();
      check("abort_ram", disp_ram, exp_ram);
      check("abort_fd", 128'(fd_cnt - fd_base), 128'h1);

      // invalid data command leaves fixed mode in place
      frame1(8'h44);
      err_base = err_cnt;
      frame1(8'h41);
      check("err41_pulse", 128'(err_cnt - err_base), 128'h1);
      start_frame();
      send_bits(8'hC8, 8);
      send_bits(8'h55, 8);
      send_bits(8'h66, 8);
      end_frame();
      exp_ram[8*8 +: 8] = 8'h66;
      check("err41_mode_kept", disp_ram, exp_ram);

      // command class 00
      err_base = err_cnt;
      frame1(8'h05);
      check("err05_pulse", 128'(err_cnt - err_base), 128'h1);
      check("err05_no_change", 128'({display_on, brightness}), 128'hF);

      // reset during bit 10 of a key read
      key_scan = 32'hFFFF_FFFF;
      start_frame();
      send_bits(8'h42, 8);
      in_read = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tm_clk = 1'b0;
         wait_cyc(H);
         tm_clk = 1'b1;
         wait_cyc(H);
      end
      tm_clk = 1'b0;
      wait_cyc(H);
      check("rst_pre_oe", 128'(dio_oe), 128'h1);
      rst_n = 1'b0;
      #1;
      check("rst_oe_now", 128'(dio_oe), 128'h0);
      check("rst_ram", disp_ram, 128'h0);
      check("rst_ctrl", 128'({display_on, brightness, dio_out}), 128'h0);
      stb    = 1'b1;
      tm_clk = 1'b1;
      in_read = 1'b0;
      wait_cyc(5);
      rst_n = 1'b1;
      wait_cyc(5);
      fd_base = fd_cnt;
      frame1(8'h8F);
      check("post_rst_on", 128'(display_on), 128'h1);
      check("post_rst_bright", 128'(brightness), 128'h7);
      check("post_rst_fd", 128'(fd_cnt - fd_base), 128'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
